// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Lets NUM_REQ byte producers share one uart_tx transmitter. Requesters are
//   granted round-robin. The granted byte is latched and presented on tx_data
//   for the whole frame. The tx_enable/tx_done handshake is sequenced so that
//   each accepted byte is handed to the transmitter exactly once.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   req_valid  [NUM_REQ]   requester i has a byte pending
//   req_data   [8*NUM_REQ] byte of requester i on bits [8i+7:8i]
//   req_ready  [NUM_REQ]   one-cycle accept pulse to the granted requester
//   tx_data    [8]         byte to uart_tx, stable while busy
//   tx_enable              send request to uart_tx
//   tx_done                uart_tx idle flag (high = idle)
//   busy                   high from accept until the frame has completed
//   grant_idx  [IDX_W]     current / last granted requester
//   bytes_sent [CNT_W]     completed frames, wraps
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_enable,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx,
  output logic [CNT_W-1:0]     bytes_sent
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_FINISH
  } state_t;

  localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

  state_t               state_reg;
  logic [NUM_REQ-1:0]   req_ready_reg;
  logic [7:0]           tx_data_reg;
  logic                 tx_enable_reg;
  logic                 busy_reg;
  logic [IDX_W-1:0]     grant_idx_reg;
  logic [CNT_W-1:0]     bytes_sent_reg;

  // Candidate k is the requester k+1 places after the last grant, wrapped
  // modulo NUM_REQ. Candidate 0 therefore has the highest priority.
  logic [IDX_W-1:0]     cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]   cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      localparam logic [IDX_W:0] OFS_W = (IDX_W+1)'(gi + 1);
      logic [IDX_W:0] sum;
      // One extra bit: grant_idx + offset never reaches 2*NUM_REQ.
      assign sum          = {1'b0, grant_idx_reg} + OFS_W;
      assign cand_idx[gi] = (sum >= NUM_W) ? IDX_W'(sum - NUM_W) : sum[IDX_W-1:0];
      assign cand_hit[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [7:0]       sel_data;

  // Scanning downward lets the nearest candidate overwrite the farther ones.
  always_comb begin
    sel_idx   = grant_idx_reg;
    sel_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        sel_idx   = cand_idx[k];
        sel_found = 1'b1;
      end
    end
  end

  assign sel_data = req_data[{sel_idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      req_ready_reg  <= '0;
      tx_data_reg    <= 8'h00;
      tx_enable_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      grant_idx_reg  <= IDX_W'(NUM_REQ - 1);
      bytes_sent_reg <= '0;
    end else begin
      req_ready_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          // While tx_done is low, the transmitter is still draining a frame.
          // This can happen, for example, after a reset that arrived mid-frame.
          if (tx_done && sel_found) begin
            grant_idx_reg <= sel_idx;
            tx_data_reg   <= sel_data;
            req_ready_reg <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
            busy_reg      <= 1'b1;
            tx_enable_reg <= 1'b1;
            state_reg     <= ST_START;
          end
        end
        ST_START: begin
          // tx_done falling means the transmitter has taken the byte.
          if (!tx_done) begin
            tx_enable_reg <= 1'b0;
            state_reg     <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (tx_done) begin
            busy_reg       <= 1'b0;
            bytes_sent_reg <= bytes_sent_reg + 1'b1;
            state_reg      <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign tx_data    = tx_data_reg;
  assign tx_enable  = tx_enable_reg;
  assign busy       = busy_reg;
  assign grant_idx  = grant_idx_reg;
  assign bytes_sent = bytes_sent_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter.
//
// A behavioural transmitter drives tx_done with programmable delays.
// A frame-level reference model predicts every DUT output once per clock.
// A second instance with a 4-bit counter shares all inputs, so counter
// wrap-around is reached within a short run.
module tb_uart_tx_arbiter;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [23:0] req_data = '0;
  logic        tx_done = 1'b1;

  logic [2:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        busy;
  logic [1:0]  grant_idx;
  logic [15:0] bytes_sent;

  logic [2:0]  s_req_ready;
  logic [7:0]  s_tx_data;
  logic        s_tx_enable;
  logic        s_busy;
  logic [1:0]  s_grant_idx;
  logic [3:0]  s_bytes_sent;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(3), .IDX_W(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_enable(tx_enable),
    .tx_done(tx_done), .busy(busy), .grant_idx(grant_idx),
    .bytes_sent(bytes_sent)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .IDX_W(2), .CNT_W(4)) u_dut_w4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(s_req_ready), .tx_data(s_tx_data), .tx_enable(s_tx_enable),
    .tx_done(tx_done), .busy(s_busy), .grant_idx(s_grant_idx),
    .bytes_sent(s_bytes_sent)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the arbiter.
  bit          m_active;     // a byte has been accepted and is not yet sent
  bit          m_taken;      // transmitter has dropped tx_done for that byte
  logic [2:0]  m_ready;
  logic [7:0]  m_data;
  int          m_gidx;
  logic [15:0] m_cnt;

  function automatic int pick(input int last, input logic [2:0] v);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Apply one clock edge to the model, using the inputs the DUT samples at that edge.
  task automatic model_edge();
    m_ready = '0;
    if (!rst) begin
      m_active = 0; m_taken = 0; m_data = 8'h00; m_gidx = N - 1; m_cnt = '0;
    end else if (!m_active) begin
      if (tx_done) begin
        int s;
        s = pick(m_gidx, req_valid);
        if (s >= 0) begin
          m_gidx   = s;
          m_data   = req_data[8*s +: 8];
          m_ready  = 3'(1 << s);
          m_active = 1;
          m_taken  = 0;
        end
      end
    end else if (!m_taken) begin
      if (!tx_done) m_taken = 1;
    end else if (tx_done) begin
      m_active = 0;
      m_cnt    = m_cnt + 16'd1;
    end
  endtask

  int grant_q[$];

  task automatic compare();
    check("req_ready", req_ready, m_ready);
    check("tx_data", tx_data, m_data);
    check("tx_enable", tx_enable, m_active && !m_taken);
    check("busy", busy, m_active);
    check("grant_idx", grant_idx, m_gidx);
    check("bytes_sent", bytes_sent, m_cnt);
    check("bytes_sent_w4", s_bytes_sent, m_cnt[3:0]);
    for (int k = 0; k < N; k++)
      if (req_ready[k]) grant_q.push_back(k);
  endtask

  // Behavioural transmitter.
  int tx_phase = 0;
  int tx_cnt = 0;
  int d1 = 10;
  int d2 = 100;
  bit hold_low = 0;

  task automatic tx_update();
    if (hold_low) begin
      tx_done = 1'b0;
      tx_phase = 0;
    end else begin
      case (tx_phase)
        0: begin
          tx_done = 1'b1;
          if (tx_enable) begin
            tx_phase = 1;
            tx_cnt = d1;
          end
        end
        1: begin
          if (tx_cnt <= 1) begin
            tx_done = 1'b0;
            tx_phase = 2;
            tx_cnt = d2;
          end else tx_cnt--;
        end
        default: begin
          if (tx_cnt <= 1) begin
            tx_done = 1'b1;
            tx_phase = 0;
          end else tx_cnt--;
        end
      endcase
    end
  endtask

  task automatic cycle();
    model_edge();
    @(negedge clk);
    compare();
    tx_update();
  endtask

  task automatic run_until_grants(input string tag, input int n, input int budget);
    int start;
    start = grant_q.size();
    for (int i = 0; i < budget && grant_q.size() < start + n; i++) cycle();
    check(tag, grant_q.size() - start, n);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (!m_active) break;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    model_edge();
    compare();
    check("rst_grant_idx", grant_idx, 2);
    check("rst_busy", busy, 0);
    check("rst_tx_enable", tx_enable, 0);
    check("rst_bytes_sent", bytes_sent, 0);
    check("rst_req_ready", req_ready, 0);
    repeat (2) cycle();
    rst = 1'b1;
  endtask

  initial begin
    int base;
    @(negedge clk);
    pulse_reset();

    // Single requester, slow transmitter.
    req_valid = 3'b001;
    req_data  = 24'h000041;
    run_until_grants("t1_grant", 1, 30);
    check("t1_ready", grant_q[grant_q.size()-1], 0);
    req_valid = 3'b000;
    run_until_idle("t1_idle", 400);
    check("t1_bytes", bytes_sent, 1);
    check("t1_data", tx_data, 8'h41);

    // All three requesters, six frames from fresh reset.
    pulse_reset();
    d1 = 2; d2 = 6;
    req_valid = 3'b111;
    req_data  = 24'h302010;
    base = grant_q.size();
    run_until_grants("t2_grants", 6, 300);
    req_valid = 3'b000;
    run_until_idle("t2_idle", 100);
    for (int k = 0; k < 6; k++) check("t2_order", grant_q[base+k], k % 3);
    check("t2_bytes", bytes_sent, 6);

    // After a grant to 1, only requesters 0 and 2 are valid.
    req_valid = 3'b010;
    run_until_grants("t3_g1", 1, 50);
    req_valid = 3'b000;
    run_until_idle("t3_idle1", 100);
    req_valid = 3'b101;
    base = grant_q.size();
    run_until_grants("t3_grants", 2, 200);
    req_valid = 3'b000;
    run_until_idle("t3_idle2", 100);
    check("t3_first", grant_q[base], 2);
    check("t3_second", grant_q[base+1], 0);

    // tx_done low across reset release: no grant until it rises.
    hold_low = 1;
    tx_done = 1'b0;
    pulse_reset();
    req_valid = 3'b010;
    base = grant_q.size();
    repeat (20) cycle();
    check("t4_no_grant", grant_q.size() - base, 0);
    hold_low = 0;
    run_until_grants("t4_grant", 1, 20);
    check("t4_idx", grant_q[base], 1);
    req_valid = 3'b000;
    run_until_idle("t4_idle", 100);

    // Reset while in the wait-for-done phase.
    d1 = 3; d2 = 30;
    req_valid = 3'b010;
    for (int i = 0; i < 100 && !(m_active && m_taken); i++) cycle();
    check("t5_reach_finish", busy, 1);
    repeat (3) cycle();
    pulse_reset();
    req_valid = 3'b111;
    base = grant_q.size();
    run_until_grants("t5_grant", 1, 100);
    check("t5_first_after_rst", grant_q[base], 0);
    req_valid = 3'b000;
    run_until_idle("t5_idle", 100);

    // Randomised traffic with random transmitter timing.
    base = grant_q.size();
    for (int i = 0; i < 4000 && grant_q.size() < base + 60; i++) begin
      req_valid = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) req_data = 24'($urandom);
      if (tx_phase == 0) begin
        d1 = $urandom_range(1, 4);
        d2 = $urandom_range(1, 12);
      end
      cycle();
    end
    check("t6_grants", (grant_q.size() - base) >= 60, 1);
    req_valid = 3'b000;
    run_until_idle("t6_idle", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
